// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a small byte FIFO with a valid/ready write port.
// Queued bytes are sent back-to-back; the line idles high.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic                          i_TX_DV,
  input  logic [7:0]                    i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam logic [CNTW-1:0] LAST     = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] PRE_LAST = CNTW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Reset asserts asynchronously, releases two edges after the input deasserts.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push, pop;

  state_t        state, state_n;
  logic [CNTW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    sh, sh_n;
  logic          line_n, bit_end;

  // Ready comes from the registered count, so a write while full is dropped
  // even when the transmitter pops on the same edge.
  assign o_TX_Ready   = (count < CW'(FIFO_DEPTH));
  assign push         = i_TX_DV & o_TX_Ready;
  assign o_FIFO_Count = count;
  assign o_TX_Active  = (state != IDLE);
  assign bit_end      = (clk_cnt == LAST);

  always_ff @(posedge i_Clk) begin
    if (push) mem[wptr] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    line_n    = o_TX_Serial;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        line_n = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          sh_n      = mem[rptr];
          line_n    = 1'b0;
          clk_cnt_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          line_n    = sh[0];
          sh_n      = {1'b0, sh[7:1]};
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt + CNTW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            line_n  = 1'b1;
            state_n = STOP;
          end else begin
            line_n    = sh[0];
            sh_n      = {1'b0, sh[7:1]};
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNTW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count != '0) begin
            pop     = 1'b1;
            sh_n    = mem[rptr];
            line_n  = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNTW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Done   <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      sh          <= sh_n;
      o_TX_Serial <= line_n;
      // Registered so Done is high exactly during the stop bit's final cycle.
      o_TX_Done   <= (state == STOP) && (clk_cnt == PRE_LAST);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a CLKS_PER_BIT=4 instance for frame timing
// and FIFO corners, and a CLKS_PER_BIT=217 instance for the wrap-around run.
module tb_uart_tx_fifo;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       dv4 = 1'b0, dv2 = 1'b0;
  logic [7:0] d4 = 8'h00, d2 = 8'h00;
  logic       rdy4, ser4, act4, done4;
  logic       rdy2, ser2, act2, done2;
  logic [2:0] cnt4, cnt2;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TX_DV(dv4), .i_TX_Byte(d4),
    .o_TX_Ready(rdy4), .o_TX_Serial(ser4), .o_TX_Active(act4),
    .o_TX_Done(done4), .o_FIFO_Count(cnt4));

  uart_tx_fifo #(.CLKS_PER_BIT(217), .FIFO_DEPTH(4)) dut217 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TX_DV(dv2), .i_TX_Byte(d2),
    .o_TX_Ready(rdy2), .o_TX_Serial(ser2), .o_TX_Active(act2),
    .o_TX_Done(done2), .o_FIFO_Count(cnt2));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference receiver per instance: start detected on first low sample,
  // each bit sampled near its middle.
  bit         rx_busy [2];
  int         rx_tmr  [2];
  int         rx_bit  [2];
  logic [7:0] rx_sh   [2];
  logic [7:0] rxq4[$], rxq2[$];
  logic       rx_s;
  int         rx_c;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rx_s = (k == 1) ? ser2 : ser4;
      rx_c = (k == 1) ? 217 : 4;
      if (!rst_n) begin
        rx_busy[k] = 1'b0;
      end else if (!rx_busy[k]) begin
        if (rx_s == 1'b0) begin
          rx_busy[k] = 1'b1;
          rx_tmr[k]  = rx_c + rx_c / 2;
          rx_bit[k]  = 0;
        end
      end else begin
        rx_tmr[k]--;
        if (rx_tmr[k] == 0) begin
          if (rx_bit[k] < 8) begin
            rx_sh[k][rx_bit[k]] = rx_s;
            rx_bit[k]++;
            rx_tmr[k] = rx_c;
          end else begin
            chk("rx_stop_bit", 32'(rx_s), 32'd1);
            if (k == 1) rxq2.push_back(rx_sh[k]);
            else        rxq4.push_back(rx_sh[k]);
            rx_busy[k] = 1'b0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;   // bits[0] = start, bits[9] = stop
  } frame_t;
  frame_t tbl[6];

  // Check a full frame on the fast instance, starting at the cycle the start bit appears.
  task automatic check_frame(input int ti, input string nm);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) dv4 = 1'b0;
      chk({nm, "_ser"},  32'(ser4),  32'(tbl[ti].bits[(cyc - 1) / 4]));
      chk({nm, "_act"},  32'(act4),  32'd1);
      chk({nm, "_done"}, 32'(done4), 32'(cyc == 40));
    end
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    chk({nm, "_idle_ser"},  32'(ser4),  32'd1);
    chk({nm, "_idle_act"},  32'(act4),  32'd0);
    chk({nm, "_idle_done"}, 32'(done4), 32'd0);
  endtask

  task automatic write4(input logic [7:0] b);
    @(negedge clk);
    dv4 = 1'b1;
    d4  = b;
  endtask

  task automatic wait_idle(input int k, input int maxc, input string nm);
    int n = 0;
    while (((k == 1) ? act2 : act4) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'((k == 1) ? act2 : act4), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] exp_cnt [6];
  logic       exp_rdy [6];
  logic [7:0] eb;
  int         idx;

  initial begin
    tbl[0] = '{data: 8'hA5, bits: 10'b1_10100101_0};
    tbl[1] = '{data: 8'h00, bits: 10'b1_00000000_0};
    tbl[2] = '{data: 8'hFF, bits: 10'b1_11111111_0};
    tbl[3] = '{data: 8'h3C, bits: 10'b1_00111100_0};
    tbl[4] = '{data: 8'h01, bits: 10'b1_00000001_0};
    tbl[5] = '{data: 8'h80, bits: 10'b1_10000000_0};
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ser",   32'(ser4),  32'd1);
    chk("rst_act",   32'(act4),  32'd0);
    chk("rst_done",  32'(done4), 32'd0);
    chk("rst_cnt",   32'(cnt4),  32'd0);
    chk("rst_rdy",   32'(rdy4),  32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ser",   32'(ser4), 32'd1);
    chk("post_rst_ser217", 32'(ser2), 32'd1);

    // Single frames from the table, each into an idle transmitter
    for (int i = 0; i < 6; i++) begin
      write4(tbl[i].data);
      @(negedge clk);
      dv4 = 1'b0;
      chk("single_lat_ser", 32'(ser4), 32'd1);
      chk("single_lat_cnt", 32'(cnt4), 32'd1);
      check_frame(i, "single");
      check_idle("single");
    end

    // Back-to-back: 0x00 then 0xFF on consecutive edges, no idle gap
    write4(8'h00);
    @(negedge clk);
    d4 = 8'hFF;
    chk("b2b_cnt", 32'(cnt4), 32'd1);
    check_frame(1, "b2b0");
    check_frame(2, "b2b1");
    check_idle("b2b");

    // Full / drop: six consecutive writes 0x10..0x15
    rxq4.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("full_cnt", 32'(cnt4), 32'(exp_cnt[i - 1]));
        chk("full_rdy", 32'(rdy4), 32'(exp_rdy[i - 1]));
      end
      dv4 = 1'b1;
      d4  = 8'h10 + 8'(i);
    end
    @(negedge clk);
    dv4 = 1'b0;
    chk("full_cnt", 32'(cnt4), 32'(exp_cnt[5]));
    chk("full_rdy", 32'(rdy4), 32'(exp_rdy[5]));
    wait_idle(0, 400, "full_timeout");
    chk("full_rx_size", 32'(rxq4.size()), 32'd5);
    for (int i = 0; i < 5 && i < rxq4.size(); i++)
      chk("full_rx_byte", 32'(rxq4[i]), 32'(8'h10 + 8'(i)));
    chk("full_cnt_end", 32'(cnt4), 32'd0);

    // Reset during data bit 3 with two bytes queued
    write4(8'h52);
    @(negedge clk);
    d4 = 8'h66;
    @(negedge clk);
    d4 = 8'h77;
    @(negedge clk);
    dv4 = 1'b0;
    chk("midrst_cnt_pre", 32'(cnt4), 32'd2);
    repeat (16) @(negedge clk);
    chk("midrst_bit3", 32'(ser4), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ser", 32'(ser4), 32'd1);
    chk("midrst_cnt", 32'(cnt4), 32'd0);
    chk("midrst_rdy", 32'(rdy4), 32'd1);
    chk("midrst_act", 32'(act4), 32'd0);
    rxq4.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("midrst_quiet", 32'({ser4, act4}), 32'b10);
    end
    chk("midrst_rx_none", 32'(rxq4.size()), 32'd0);
    write4(8'h3C);
    @(negedge clk);
    dv4 = 1'b0;
    check_frame(3, "post_rst");
    check_idle("post_rst");

    // Wrap-around: 11 bytes in bursts of 3 at CLKS_PER_BIT=217
    rxq2.delete();
    idx = 0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < ((b == 3) ? 2 : 3); j++) begin
        @(negedge clk);
        dv2 = 1'b1;
        d2  = 8'h30 + 8'(idx * 7);
        idx++;
      end
      @(negedge clk);
      dv2 = 1'b0;
      wait_idle(1, 8000, "wrap_timeout");
      repeat (20) @(negedge clk);
    end
    chk("wrap_rx_size", 32'(rxq2.size()), 32'd11);
    for (int i = 0; i < 11 && i < rxq2.size(); i++) begin
      eb = 8'h30 + 8'(i * 7);
      chk("wrap_rx_byte", 32'(rxq2[i]), 32'(eb));
    end
    chk("wrap_cnt_end", 32'(cnt2), 32'd0);
    chk("wrap_ser_end", 32'(ser2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter for the synth's serial link: 115200 baud, 8 data bits, no parity, 1 stop bit, no flow control.
- This is the transmit end of the link whose receive side feeds MIDI bytes into the design. It is used for MIDI-thru and debug echo.
- A small byte FIFO with a valid/ready write port decouples producers from the serial line. Queued bytes go out back-to-back with no idle gap.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit (CLK_FREQ/BAUD; 217 at 25 MHz). Must be ≥ 2.
- FIFO_DEPTH, 4, byte entries. Must be a power of two, ≥ 2.

Ports:
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst_n  in  1  asynchronous active-low reset
- i_TX_DV  in  1  write strobe; byte accepted on a clock edge where i_TX_DV=1 and o_TX_Ready=1
- i_TX_Byte  in  8  byte to queue
- o_TX_Ready  out  1  FIFO not full (count < FIFO_DEPTH)
- o_TX_Serial  out  1  serial line, idles high, registered
- o_TX_Active  out  1  high while a frame is on the line (START, DATA, STOP states)
- o_TX_Done  out  1  1-cycle pulse at completion of each stop bit
- o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being sent

Behaviour:
- Reset (async assert, sync release): o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_FIFO_Count=0, o_TX_Ready=1, state=IDLE, pointers and bit/clock counters=0.
- Reset asserted mid-frame aborts the frame immediately: line goes high and the FIFO is flushed.
- FIFO write/read:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - o_TX_Ready is derived from the registered count only.
  - A write while full is dropped silently, even if a pop occurs on the same edge.
  - Push and pop on the same edge leave the count unchanged.
  - Order is strictly FIFO.
- State machine IDLE, START, DATA, STOP:
  - IDLE: line=1. If count>0 at the edge: pop the head into the shift register, drive line=0, clear the clock counter, go to START. With count=0, stay in IDLE.
  - START: hold line=0 for exactly CLKS_PER_BIT cycles, then drive bit 0 and go to DATA with bit index 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7's final cycle, drive line=1 and go to STOP.
  - STOP: hold line=1 for CLKS_PER_BIT cycles. On its final cycle, pulse o_TX_Done for one cycle. Then:
    - count>0: pop the next byte, drive line=0, go to START (no idle cycle).
    - count=0: go to IDLE.
- Timing:
  - Frame length is exactly 10×CLKS_PER_BIT cycles.
  - Latency: a byte written at edge E into an empty FIFO with state IDLE drives the line low at edge E+1.
  - A push in the same cycle IDLE sees count=0 is not popped until the next edge.
- Clock counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and must never overflow or wrap early.
- o_TX_Active falls on the edge entering IDLE and stays high across back-to-back frames.

Test Plan:
- Single byte (CLKS_PER_BIT=4): write 0xA5 while idle.
  - Line low one edge later.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles, then stop high for 4 cycles.
  - o_TX_Done pulses once at cycle 40; o_TX_Active high for exactly 40 cycles.
- Back-to-back: write 0x00 then 0xFF on consecutive edges.
  - Second start bit begins exactly 40 cycles after the first.
  - Line never high between the first stop bit and the second start bit.
  - Two Done pulses 40 cycles apart.
- Full/drop (FIFO_DEPTH=4): assert i_TX_DV for 6 consecutive edges with bytes 0x10..0x15.
  - Bytes 0x10..0x14 accepted; o_FIFO_Count peaks at 4 and o_TX_Ready=0 at the 6th edge.
  - 0x15 is dropped; the line carries 0x10..0x14 in order.
- Wrap-around: send 11 bytes in bursts of 3 with idle gaps.
  - All 11 are received in order by a reference UART_RX model at CLKS_PER_BIT=217.
  - o_FIFO_Count returns to 0 at the end.
- Reset mid-frame: assert i_Rst_n=0 during data bit 3 with 2 bytes queued.
  - o_TX_Serial=1 and o_FIFO_Count=0 without waiting for a clock edge.
  - After release, no further frame is sent.
  - A new write of 0x3C is sent correctly.
